// File: rtl/atom_npu_driver_if.sv
// Host/core handshake bundle for atom_npu_driver: operand push, batch control,
// core start/done pair and the per-job result stream.
interface atom_npu_driver_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_input;
    logic [3:0] op_weight;
    logic       run;
    logic       busy;
    logic       core_start;
    logic [3:0] core_input;
    logic [3:0] core_weight;
    logic [3:0] core_result;
    logic       core_done;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ready;
    logic [7:0] sum_out;
    logic       sum_valid;
    logic       err_timeout;

    modport slave (
        input  op_valid, op_input, op_weight, run, core_result, core_done, res_ready,
        output op_ready, busy, core_start, core_input, core_weight,
               res_valid, res_data, sum_out, sum_valid, err_timeout
    );

    modport master (
        output op_valid, op_input, op_weight, run, core_result, core_done, res_ready,
        input  op_ready, busy, core_start, core_input, core_weight,
               res_valid, res_data, sum_out, sum_valid, err_timeout
    );
endinterface

// File: rtl/atom_npu_driver.sv
// Batch initiator for atom_npu_core: buffers operand pairs, issues one job at a
// time, streams results with backpressure and reports a saturating batch sum.
module atom_npu_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    atom_npu_driver_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_FINISH
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic [3:0]    cin_q, cwt_q, res_q;
    logic [7:0]    sum_q;
    logic          err_q;

    logic          push, pop, flush, go;
    logic [7:0]    head, head_nxt;
    logic [8:0]    sum_ext;

    assign bus.op_ready    = (state == S_IDLE) && (count < CW'(DEPTH));
    assign bus.busy        = (state != S_IDLE);
    assign bus.core_start  = (state == S_ISSUE);
    assign bus.res_valid   = (state == S_EMIT);
    assign bus.sum_valid   = (state == S_FINISH);
    assign bus.core_input  = cin_q;
    assign bus.core_weight = cwt_q;
    assign bus.res_data    = res_q;
    assign bus.sum_out     = sum_q;
    assign bus.err_timeout = err_q;

    assign push   = bus.op_valid && bus.op_ready;
    // A pair pushed in the run cycle counts toward the batch, even into an empty buffer.
    assign go     = (state == S_IDLE) && bus.run && ((count != '0) || push);
    assign pop    = (state == S_EMIT) && bus.res_ready;
    assign flush  = (state == S_WAIT) && !bus.core_done && (timer == TW'(TIMEOUT - 1));
    assign rd_nxt = rd_ptr + 1'b1;
    assign head   = (count == '0) ? {bus.op_weight, bus.op_input} : mem[rd_ptr];
    assign head_nxt = mem[rd_nxt];
    assign sum_ext  = {1'b0, sum_q} + {5'b0, bus.core_result};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            timer  <= '0;
            cin_q  <= '0;
            cwt_q  <= '0;
            res_q  <= '0;
            sum_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.op_weight, bus.op_input};
                wr_ptr      <= wr_ptr + 1'b1;
            end

            if (flush)      count <= '0;
            else if (push)  count <= count + 1'b1;
            else if (pop)   count <= count - 1'b1;

            case (state)
                S_IDLE: if (go) begin
                    state <= S_ISSUE;
                    sum_q <= '0;
                    err_q <= 1'b0;
                    cin_q <= head[3:0];
                    cwt_q <= head[7:4];
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.core_done) begin
                        res_q <= bus.core_result;
                        sum_q <= sum_ext[8] ? 8'hFF : sum_ext[7:0];
                        state <= S_EMIT;
                    end else if (flush) begin
                        err_q  <= 1'b1;
                        rd_ptr <= wr_ptr;
                        state  <= S_FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_EMIT: if (pop) begin
                    rd_ptr <= rd_nxt;
                    if (count == CW'(1)) begin
                        state <= S_FINISH;
                    end else begin
                        cin_q <= head_nxt[3:0];
                        cwt_q <= head_nxt[7:4];
                        state <= S_ISSUE;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atom_npu_driver.sv
// Directed bench for atom_npu_driver with a behavioural atom_npu_core
// (result = min(input*weight, 15), done seen 7 cycles after start).
module tb_atom_npu_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atom_npu_driver_if bif();

    atom_npu_driver #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // core model; stub forces core_done low to exercise the timeout path
    logic       stub = 1'b0;
    logic       mdl_done;
    logic [3:0] mdl_res;
    logic [2:0] mdl_cnt;
    logic [7:0] prod;
    assign prod = bif.core_input * bif.core_weight;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_done <= 1'b0;
            mdl_res  <= '0;
            mdl_cnt  <= '0;
        end else if (bif.core_start) begin
            mdl_done <= 1'b0;
            mdl_cnt  <= 3'd6;
            mdl_res  <= (prod > 8'd15) ? 4'd15 : prod[3:0];
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1'b1;
            if (mdl_cnt == 3'd1) mdl_done <= 1'b1;
        end
    end
    assign bif.core_done   = stub ? 1'b0 : mdl_done;
    assign bif.core_result = mdl_res;

    // operands may only change in a core_start cycle while busy
    int         viol = 0;
    logic [3:0] pin = '0, pwt = '0;
    always @(negedge clk) begin
        if (bif.busy && !bif.core_start &&
            (bif.core_input !== pin || bif.core_weight !== pwt))
            viol <= viol + 1;
        pin <= bif.core_input;
        pwt <= bif.core_weight;
    end

    int         starts[$];
    logic [3:0] rq[$];
    int         rcyc[$];
    int         stall_n = 0;
    int         hold_err = 0;

    function automatic logic [31:0] rv(input int k);
        return (k < rq.size()) ? {28'd0, rq[k]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int sc(input int k);
        return (k < starts.size()) ? starts[k] : -1000;
    endfunction

    task automatic push(input logic [3:0] i, input logic [3:0] w);
        @(negedge clk);
        bif.op_valid  = 1'b1;
        bif.op_input  = i;
        bif.op_weight = w;
        @(negedge clk);
        bif.op_valid  = 1'b0;
    endtask

    // run cycle is cycle 0; sv_cyc is the cycle sum_valid is seen
    task automatic run_batch(output int sv_cyc);
        int c;
        logic [3:0] held;
        bit have;
        starts.delete(); rq.delete(); rcyc.delete();
        hold_err = 0; have = 0; sv_cyc = -1; held = '0;
        @(negedge clk);
        bif.run = 1'b1;
        bif.res_ready = 1'b1;
        c = 0;
        while (sv_cyc < 0 && c < 400) begin
            @(negedge clk);
            bif.run = 1'b0;
            c++;
            if (bif.core_start) starts.push_back(c);
            if (bif.res_valid) begin
                if (stall_n > 0) begin
                    bif.res_ready = 1'b0;
                    stall_n--;
                    if (!have) begin held = bif.res_data; have = 1; end
                    else if (bif.res_data !== held) hold_err++;
                end else begin
                    bif.res_ready = 1'b1;
                    rq.push_back(bif.res_data);
                    rcyc.push_back(c);
                end
            end
            if (bif.sum_valid) sv_cyc = c;
        end
        if (sv_cyc < 0) chk("batch_end_timeout", 0, 1);
    endtask

    task automatic empty_run(input string tag);
        bit seen = 0;
        @(negedge clk);
        bif.run = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bif.run = 1'b0;
            if (bif.busy || bif.sum_valid) seen = 1;
        end
        chk(tag, {31'd0, seen}, 0);
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_op_ready"}, bif.op_ready, 1);
        chk({p, "_busy"}, bif.busy, 0);
        chk({p, "_core_start"}, bif.core_start, 0);
        chk({p, "_core_input"}, bif.core_input, 0);
        chk({p, "_core_weight"}, bif.core_weight, 0);
        chk({p, "_res_valid"}, bif.res_valid, 0);
        chk({p, "_res_data"}, bif.res_data, 0);
        chk({p, "_sum_out"}, bif.sum_out, 0);
        chk({p, "_sum_valid"}, bif.sum_valid, 0);
        chk({p, "_err"}, bif.err_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv, vb, n;
        logic [3:0] bi[4] = '{4'd2, 4'd7, 4'd1, 4'd4};
        logic [3:0] bw[4] = '{4'd3, 4'd9, 4'd0, 4'd1};
        logic [3:0] be[4] = '{4'd6, 4'd15, 4'd0, 4'd4};
        logic [3:0] fe[4] = '{4'd1, 4'd4, 4'd9, 4'd2};

        bif.op_valid = 1'b0; bif.op_input = '0; bif.op_weight = '0;
        bif.run = 1'b0; bif.res_ready = 1'b1;
        #12;
        chk_rst("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single pair (3,5) -> 15
        push(4'd3, 4'd5);
        vb = viol;
        run_batch(sv);
        chk("t1_nstart", starts.size(), 1);
        chk("t1_issue_cyc", sc(0), 1);
        chk("t1_nres", rq.size(), 1);
        chk("t1_res", rv(0), 15);
        chk("t1_emit_lat", (rcyc.size() > 0) ? rcyc[0] - sc(0) : -1, 8);
        chk("t1_sv_cyc", sv, 10);
        chk("t1_sum", bif.sum_out, 15);
        chk("t1_stable", viol - vb, 0);

        // four-pair batch
        for (int k = 0; k < 4; k++) push(bi[k], bw[k]);
        vb = viol;
        run_batch(sv);
        chk("t2_nres", rq.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_res%0d", k), rv(k), {28'd0, be[k]});
        for (int k = 1; k < 4; k++) chk($sformatf("t2_gap%0d", k), sc(k) - sc(k-1), 9);
        chk("t2_sv_cyc", sv, 37);
        chk("t2_sum", bif.sum_out, 25);
        chk("t2_stable", viol - vb, 0);

        // fill, overflow attempt, then empty run
        push(4'd1, 4'd1); push(4'd2, 4'd2); push(4'd3, 4'd3); push(4'd1, 4'd2);
        chk("t3_full_ready", bif.op_ready, 0);
        push(4'd9, 4'd9);
        run_batch(sv);
        chk("t3_nres", rq.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t3_res%0d", k), rv(k), {28'd0, fe[k]});
        chk("t3_sum", bif.sum_out, 16);
        empty_run("t3_empty_run");
        chk("t3_sum_hold", bif.sum_out, 16);

        // backpressure: 20 stalled cycles on the first result
        push(4'd2, 4'd2); push(4'd3, 4'd1);
        stall_n = 20;
        run_batch(sv);
        chk("t4_hold", hold_err, 0);
        chk("t4_nstart", starts.size(), 2);
        chk("t4_start2_cyc", sc(1), 30);
        chk("t4_res0", rv(0), 4);
        chk("t4_res1", rv(1), 3);
        chk("t4_sv_cyc", sv, 39);
        chk("t4_sum", bif.sum_out, 7);

        // timeout with a dead core
        stub = 1'b1;
        push(4'd5, 4'd5); push(4'd1, 4'd1);
        run_batch(sv);
        chk("t5_sv_cyc", sv, 17);
        chk("t5_nres", rq.size(), 0);
        chk("t5_nstart", starts.size(), 1);
        chk("t5_err", bif.err_timeout, 1);
        chk("t5_sum", bif.sum_out, 0);
        @(negedge clk);
        chk("t5_err_sticky", bif.err_timeout, 1);
        chk("t5_ready", bif.op_ready, 1);
        stub = 1'b0;
        empty_run("t5_flushed");
        chk("t5_err_after_empty", bif.err_timeout, 1);
        push(4'd2, 4'd1);
        run_batch(sv);
        chk("t5_err_clr", bif.err_timeout, 0);
        chk("t5_nres2", rq.size(), 1);
        chk("t5_res2", rv(0), 2);
        chk("t5_sum2", bif.sum_out, 2);

        // asynchronous reset during WAIT of job 2
        push(4'd2, 4'd3); push(4'd7, 4'd9);
        @(negedge clk);
        bif.run = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 2; c++) begin
            @(negedge clk);
            bif.run = 1'b0;
            if (bif.core_start) n++;
        end
        chk("t6_job2_started", n, 2);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", bif.busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_rst("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        empty_run("t6_flushed");
        push(4'd1, 4'd4);
        run_batch(sv);
        chk("t6_nres", rq.size(), 1);
        chk("t6_res", rv(0), 4);
        chk("t6_sum", bif.sum_out, 4);
        chk("t6_sv_cyc", sv, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atom_npu_driver.md
# atom_npu_driver

Host-side initiator for the `atom_npu_core` start/done handshake. It buffers up to DEPTH (input, weight) operand pairs and, on `run`, issues them to the core one job at a time. It holds the core operands stable for the whole job, streams each 4-bit result out with backpressure, and reports a saturating batch sum plus a timeout error. It sits between `tt_um_atomNPU`'s pin logic and the core.

## Interface
Parameters:
- DEPTH, 4, operand buffer entries; power of two, 2..8
- TIMEOUT, 15, maximum WAIT cycles allowed for `core_done`; must be ≥ 8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operand pair offered
- op_ready  out  1  pair accepted this cycle when op_valid & op_ready
- op_input  in  4  operand input value
- op_weight  in  4  operand weight value
- run  in  1  start batch; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- core_start  out  1  one-cycle job start to the core
- core_input  out  4  to core input_data; held for the whole job
- core_weight  out  4  to core weight; held for the whole job
- core_result  in  4  core output_data
- core_done  in  1  core done; level, cleared by the core when it accepts a start
- res_valid  out  1  per-job result available
- res_data  out  4  per-job result
- res_ready  in  1  result consumer ready
- sum_out  out  8  saturating sum of the batch's results
- sum_valid  out  1  one-cycle pulse at batch end
- err_timeout  out  1  sticky; cleared at next accepted run

## Operation
- Buffer: DEPTH-entry FIFO of {weight, input} with read ptr, write ptr and count; pointers wrap modulo DEPTH.
  - op_ready = (state == IDLE) && (count < DEPTH).
  - A push while full is impossible (op_ready=0); pushes outside IDLE are ignored.
- IDLE:
  - run && count>0 → ISSUE; clear sum_out and err_timeout.
  - run && count==0 → ignored, no sum_valid.
  - A push and run in the same cycle: the push is accepted and counted.
- ISSUE (1 cycle):
  - core_start=1; core_input/core_weight = FIFO head.
  - Clear the WAIT timer → WAIT.
- WAIT:
  - Ignore core_start; core_input/core_weight stay at the head entry.
  - core_done=1 → latch res_data=core_result; sum_out = min(sum_out + core_result, 255) → EMIT.
  - Otherwise increment the timer. After TIMEOUT WAIT cycles without done: err_timeout=1, flush FIFO (count=0, ptrs equal) → FINISH.
- EMIT:
  - res_valid=1; res_data held stable until the handshake.
  - res_valid && res_ready: pop head; remaining count 0 → FINISH, else → ISSUE.
- FINISH (1 cycle): sum_valid=1 → IDLE.
- core_start, res_valid, sum_valid and busy decode from the registered state and carry no combinational path from inputs.
- Arithmetic:
  - Sum uses 9-bit intermediate and clamps at 8'hFF. Maximum legal batch is 8×15=120, so the clamp exists only for robustness.
  - Results are not re-saturated; values come from the core already clamped to 15.

## Timing
- Reset values: op_ready=1 (empty, IDLE), busy=0, core_start=0, core_input=0, core_weight=0, res_valid=0, res_data=0, sum_out=0, sum_valid=0, err_timeout=0, count=0, state=IDLE.
- Job latency with the core attached, start in cycle 0:
  - core_done is seen high in cycle 7.
  - EMIT occupies cycle 8; with res_ready=1 the next ISSUE is in cycle 9.
  - Result: 9 cycles per pair and 9N+2 cycles from run to sum_valid, counting the run cycle and FINISH.
- core_done may still be high from the previous job during ISSUE. It is not sampled there, and the core drops it on the edge ending ISSUE.
- res_ready held low stalls EMIT indefinitely. The core idles with done high, which is harmless.
- run, op_valid and pushes while busy are ignored; sum_out holds its value until the next accepted run.
- Asynchronous reset mid-batch returns everything to reset values immediately and discards all buffered pairs.

## Test plan
- Single pair (3,5), run, res_ready=1 → core_start pulse 1 cycle; res_data=15 in EMIT, cycle 8; sum_valid with sum_out=15 at cycle 10.
- Batch (2,3),(7,9),(1,0),(4,1) → res_data sequence 6,15,0,4; sum_out=25; pulses 9 cycles apart; core_input/core_weight stable through every WAIT.
- Fill DEPTH=4 pairs then op_valid in the next cycle → op_ready=0, 5th pair dropped; run on an empty buffer → busy stays 0, no sum_valid.
- Hold res_ready=0 for 20 cycles on the first result → res_valid and res_data held, no second core_start; release → batch completes with correct sum.
- Replace the core with a stub tying core_done=0 → err_timeout=1 after 15 WAIT cycles; FIFO flushed; sum_valid pulses; next run clears err_timeout.
- Assert rst_n=0 during WAIT of job 2 → all outputs at reset values asynchronously; count=0; new batch afterwards runs correctly.
